// File: rtl/smart_home_pkg.sv
// Shared widths, window depth and sensor reset levels for the smart-home front end.
package smart_home_pkg;
  localparam int TEMP_W    = 8;
  localparam int SUM_W     = 10;
  localparam int AVG_DEPTH = 4;

  localparam logic LIGHT_RST = 1'b1;
  localparam logic OTHER_RST = 1'b0;

  typedef logic [TEMP_W-1:0] temp_t;
  typedef logic [SUM_W-1:0]  sum_t;
endpackage

// File: rtl/sensor_debounce.sv
// One sensor channel: 2-FF synchroniser followed by a tick-driven debounce counter,
// with an optional undebounced rising edge for safety-critical inputs.
module sensor_debounce #(
  parameter int   DEBOUNCE_TICKS = 8,
  parameter bit   FAST_RISE      = 1'b0,
  parameter logic RST_VAL        = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic level
);
  localparam int CW = (DEBOUNCE_TICKS < 2) ? 1 : $clog2(DEBOUNCE_TICKS + 1);

  logic          meta_q;
  logic          sync_q;
  logic [CW-1:0] cnt;

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Synchroniser starts at the output's reset level so no phantom change is counted.
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      cnt    <= '0;
      level  <= RST_VAL;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
      if (sync_q == level) begin
        cnt <= '0;
      end else if (FAST_RISE && sync_q && !level) begin
        level <= 1'b1;
        cnt   <= '0;
      end else if (tick) begin
        if (cnt == CW'(DEBOUNCE_TICKS - 1)) begin
          level <= sync_q;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/sensor_conditioner.sv
// Sensor front end: debounced binary sensors sharing one tick prescaler, plus a
// 4-sample moving-average temperature with out-of-range sample rejection and fault flag.
module sensor_conditioner
  import smart_home_pkg::*;
#(
  parameter int    TICK_DIV       = 1000,
  parameter int    DEBOUNCE_TICKS = 8,
  parameter temp_t TEMP_MAX       = 8'd125,
  parameter int    FAULT_LIMIT    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TEMP_W-1:0] temp_raw,
  input  logic              temp_raw_valid,
  input  logic              light_raw,
  input  logic              motion_raw,
  input  logic              gas_raw,
  input  logic              door_raw,
  input  logic              rain_raw,
  output logic [TEMP_W-1:0] temperature,
  output logic              temp_ready,
  output logic              temp_update,
  output logic              temp_fault,
  output logic              light_sensor,
  output logic              motion_sensor,
  output logic              gas_sensor,
  output logic              door_sensor,
  output logic              rain_sensor
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int FW = $clog2(AVG_DEPTH + 1);
  localparam int RW = (FAULT_LIMIT < 2) ? 1 : $clog2(FAULT_LIMIT + 1);
  localparam int AVG_SHIFT = $clog2(AVG_DEPTH);

  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick = (pre_cnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset)     pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  sensor_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .FAST_RISE(1'b0), .RST_VAL(LIGHT_RST)) u_light (
    .clk(clk), .reset(reset), .tick(tick), .raw(light_raw), .level(light_sensor));
  sensor_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .FAST_RISE(1'b0), .RST_VAL(OTHER_RST)) u_motion (
    .clk(clk), .reset(reset), .tick(tick), .raw(motion_raw), .level(motion_sensor));
  sensor_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .FAST_RISE(1'b1), .RST_VAL(OTHER_RST)) u_gas (
    .clk(clk), .reset(reset), .tick(tick), .raw(gas_raw), .level(gas_sensor));
  sensor_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .FAST_RISE(1'b0), .RST_VAL(OTHER_RST)) u_door (
    .clk(clk), .reset(reset), .tick(tick), .raw(door_raw), .level(door_sensor));
  sensor_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .FAST_RISE(1'b0), .RST_VAL(OTHER_RST)) u_rain (
    .clk(clk), .reset(reset), .tick(tick), .raw(rain_raw), .level(rain_sensor));

  temp_t         window [AVG_DEPTH];
  sum_t          sum;
  logic [FW-1:0] fill;
  logic [RW-1:0] rej_cnt;

  logic          accept;
  logic          reject;
  sum_t          sum_next;
  logic [FW-1:0] fill_next;
  logic [RW-1:0] rej_next;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    accept    = temp_raw_valid && (temp_raw <= TEMP_MAX);
    reject    = temp_raw_valid && (temp_raw > TEMP_MAX);
    sum_next  = sum + SUM_W'(temp_raw) - SUM_W'(window[AVG_DEPTH-1]);
    fill_next = (fill == FW'(AVG_DEPTH)) ? fill : fill + 1'b1;
    rej_next  = (rej_cnt == RW'(FAULT_LIMIT)) ? rej_cnt : rej_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the window is reset on purpose; the running sum subtracts the
      // oldest entry, which must read as zero while the window is still filling.
      for (int i = 0; i < AVG_DEPTH; i++) window[i] <= '0;
      sum         <= '0;
      fill        <= '0;
      rej_cnt     <= '0;
      temperature <= '0;
      temp_ready  <= 1'b0;
      temp_update <= 1'b0;
      temp_fault  <= 1'b0;
    end else begin
      temp_update <= 1'b0;
      if (accept) begin
        for (int i = AVG_DEPTH - 1; i > 0; i--) window[i] <= window[i-1];
        window[0]  <= temp_raw;
        sum        <= sum_next;
        fill       <= fill_next;
        rej_cnt    <= '0;
        temp_fault <= 1'b0;
        if (fill_next == FW'(AVG_DEPTH)) begin
          temperature <= sum_next[AVG_SHIFT +: TEMP_W];
          temp_update <= 1'b1;
          temp_ready  <= 1'b1;
        end
      end else if (reject) begin
        rej_cnt    <= rej_next;
        temp_fault <= (rej_next >= RW'(FAULT_LIMIT));
      end
    end
  end
endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench: stimulus pushes expected averages and sensor-level changes,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_sensor_conditioner;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] temp_raw;
  logic       temp_raw_valid;
  logic       light_raw, motion_raw, gas_raw, door_raw, rain_raw;
  logic [7:0] temperature;
  logic       temp_ready, temp_update, temp_fault;
  logic       light_sensor, motion_sensor, gas_sensor, door_sensor, rain_sensor;

  always #5 clk = ~clk;

  sensor_conditioner #(
    .TICK_DIV(4), .DEBOUNCE_TICKS(3), .TEMP_MAX(8'd125), .FAULT_LIMIT(4)
  ) dut (
    .clk(clk), .reset(reset), .temp_raw(temp_raw), .temp_raw_valid(temp_raw_valid),
    .light_raw(light_raw), .motion_raw(motion_raw), .gas_raw(gas_raw),
    .door_raw(door_raw), .rain_raw(rain_raw),
    .temperature(temperature), .temp_ready(temp_ready), .temp_update(temp_update),
    .temp_fault(temp_fault), .light_sensor(light_sensor), .motion_sensor(motion_sensor),
    .gas_sensor(gas_sensor), .door_sensor(door_sensor), .rain_sensor(rain_sensor)
  );

  typedef struct {
    logic [7:0] temp;
    logic       fault;
  } temp_exp_t;

  temp_exp_t  temp_q [$];
  logic [4:0] sens_q [$];
  logic [4:0] prev_vec;
  logic       mon_en = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_temp(input logic [7:0] v);
    temp_raw       = v;
    temp_raw_valid = 1'b1;
    step(1);
    temp_raw_valid = 1'b0;
  endtask

  // Vector order: {light, motion, gas, door, rain}
  always @(negedge clk) begin
    logic [4:0] cur;
    cur = {light_sensor, motion_sensor, gas_sensor, door_sensor, rain_sensor};
    if (reset) begin
      prev_vec = cur;
    end else if (mon_en) begin
      if (temp_update) begin
        if (temp_q.size() == 0) begin
          check("temp_update_unexpected", temp_update, 0);
        end else begin
          temp_exp_t e;
          e = temp_q.pop_front();
          check("temp_avg", temperature, e.temp);
          check("temp_fault_at_update", temp_fault, e.fault);
          check("temp_ready_at_update", temp_ready, 1);
        end
      end
      if (cur != prev_vec) begin
        if (sens_q.size() == 0) check("sensor_change_unexpected", cur, prev_vec);
        else                    check("sensor_vector", cur, sens_q.pop_front());
        prev_vec = cur;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise, fall;
    reset = 1'b1; temp_raw = '0; temp_raw_valid = 1'b0;
    light_raw = 1'b1; motion_raw = 1'b0; gas_raw = 1'b0; door_raw = 1'b0; rain_raw = 1'b0;
    step(3);
    check("rst_light", light_sensor, 1);
    check("rst_others", {motion_sensor, gas_sensor, door_sensor, rain_sensor}, 0);
    check("rst_temp", {temperature, temp_ready, temp_update, temp_fault}, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    step(5);

    // Motion: held level rises within 2 sync + 9..12 cycles
    motion_raw = 1'b1;
    sens_q.push_back(5'b11000);
    rise = 0;
    for (int n = 1; n <= 20; n++) begin
      step(1);
      if (motion_sensor && rise == 0) rise = n;
    end
    check_range("motion_rise_cycle", rise, 11, 14);
    motion_raw = 1'b0;
    sens_q.push_back(5'b10000);
    step(20);
    check("motion_fell", motion_sensor, 0);
    motion_raw = 1'b1;
    step(6);
    motion_raw = 1'b0;
    step(20);
    check("motion_short_pulse_ignored", motion_sensor, 0);

    // Gas: fast rise, debounced fall
    gas_raw = 1'b1;
    sens_q.push_back(5'b10100);
    sens_q.push_back(5'b10000);
    step(1);
    gas_raw = 1'b0;
    step(1);
    check("gas_before_cycle3", gas_sensor, 0);
    step(1);
    check("gas_fast_rise_cycle3", gas_sensor, 1);
    fall = 0;
    for (int n = 4; n <= 20; n++) begin
      step(1);
      if (!gas_sensor && fall == 0) fall = n;
    end
    check_range("gas_fall_cycle", fall, 12, 15);

    // Temperature averaging, back-to-back strobes
    temp_q.push_back('{8'd27, 1'b0});
    temp_q.push_back('{8'd28, 1'b0});
    temp_q.push_back('{8'd22, 1'b0});
    send_temp(8'd24);
    send_temp(8'd26);
    send_temp(8'd28);
    check("temp_not_ready_at_3", {temp_ready, temperature}, 0);
    send_temp(8'd30);
    check("temp_ready_at_4", temp_ready, 1);
    check("temp_avg_first", temperature, 27);
    send_temp(8'd30);
    send_temp(8'd1);
    check("temp_avg_after_1", temperature, 22);

    // Out-of-range rejection and fault
    send_temp(8'd200);
    send_temp(8'd200);
    send_temp(8'd200);
    check("fault_after_3_rejects", temp_fault, 0);
    send_temp(8'd200);
    check("fault_after_4_rejects", temp_fault, 1);
    check("temp_held_on_reject", temperature, 22);
    temp_q.push_back('{8'd21, 1'b0});
    send_temp(8'd25);
    check("fault_cleared_by_accept", temp_fault, 0);
    check("temp_after_recovery", temperature, 21);
    send_temp(8'd126);
    check("boundary_126_rejected", temperature, 21);
    temp_q.push_back('{8'd45, 1'b0});
    send_temp(8'd125);
    check("boundary_125_accepted", temperature, 45);
    step(3);

    // Reset in the middle of a light debounce
    light_raw = 1'b0;
    step(10);
    check("light_mid_debounce", light_sensor, 1);
    reset = 1'b1;
    step(2);
    check("midrst_light", light_sensor, 1);
    check("midrst_others", {motion_sensor, gas_sensor, door_sensor, rain_sensor}, 0);
    check("midrst_temp", {temperature, temp_ready, temp_update, temp_fault}, 0);
    reset = 1'b0;
    sens_q.push_back(5'b00000);
    fall = 0;
    for (int n = 1; n <= 16; n++) begin
      step(1);
      if (!light_sensor && fall == 0) fall = n;
    end
    check("light_fall_after_reset", fall, 12);
    check("temp_ready_after_reset", temp_ready, 0);

    // Door chatter every tick, then stable
    for (int n = 0; n < 20; n++) begin
      door_raw = ~door_raw;
      step(4);
    end
    check("door_chatter_ignored", door_sensor, 0);
    door_raw = 1'b1;
    sens_q.push_back(5'b00010);
    step(20);
    check("door_stable_high", door_sensor, 1);

    step(2);
    check("temp_queue_drained", temp_q.size(), 0);
    check("sensor_queue_drained", sens_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
